// File: rtl/sic_dispatch_queue_pkg.sv
// Shared packet type and width helpers for the SIC dispatch queue.
package sic_dispatch_queue_pkg;

  localparam int NUM_SICS_DEF     = 4;
  localparam int DEPTH_DEF        = 4;
  localparam int NUM_PHY_REGS_DEF = 64;
  localparam int NUM_ECRS_DEF     = 2;
  localparam int ID_WIDTH_DEF     = 8;

  // ceil(log2(n)), never below 1 so single-entry selects still get a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int PHY_REG_W = clog2_min1(NUM_PHY_REGS_DEF);
  localparam int ECR_W     = clog2_min1(NUM_ECRS_DEF);

  typedef struct packed {
    logic                    valid;
    logic [ID_WIDTH_DEF-1:0] issue_id;
    logic [5:0]              opcode;
    logic [PHY_REG_W-1:0]    dst_reg;
    logic [PHY_REG_W-1:0]    src_a;
    logic [PHY_REG_W-1:0]    src_b;
    logic [ECR_W-1:0]        ecr_sel;
  } sic_packet_s;

endpackage

// File: rtl/sic_dispatch_queue_rr_picker.sv
// Rotating-priority first-one finder: first set req bit at or above ptr, wrapping.
module sic_rr_picker
  import sic_dispatch_queue_pkg::*;
#(
  parameter  int NUM_SICS = NUM_SICS_DEF,
  localparam int IDX_W    = clog2_min1(NUM_SICS)
) (
  input  logic [NUM_SICS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_SICS-1:0] grant,
  output logic [IDX_W-1:0]    idx,
  output logic                any
);

  int pos;

  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int off = 0; off < NUM_SICS; off++) begin
      pos = (int'(ptr) + off) % NUM_SICS;
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sic_dispatch_queue.sv
// In-order ring buffer feeding idle SICs round-robin, with redirect-driven tail truncation.
module sic_dispatch_queue
  import sic_dispatch_queue_pkg::*;
#(
  parameter int NUM_SICS     = NUM_SICS_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int NUM_PHY_REGS = NUM_PHY_REGS_DEF,
  parameter int NUM_ECRS     = NUM_ECRS_DEF,
  parameter int ID_WIDTH     = ID_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  sic_packet_s                in_pkt,
  output logic                       in_ready,
  input  logic [NUM_SICS-1:0]        sic_req_instr,
  output sic_packet_s                sic_pkt_out [NUM_SICS],
  input  logic                       flush_valid,
  input  logic [ID_WIDTH-1:0]        flush_issue_id,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam type sic_packet_t = sic_packet_s;
  localparam int  PTR_W = $clog2(DEPTH);
  localparam int  CNT_W = $clog2(DEPTH) + 1;
  localparam int  IDX_W = clog2_min1(NUM_SICS);

  // The packet layout is fixed by the package; other field widths cannot be honoured.
  if (ID_WIDTH != ID_WIDTH_DEF || NUM_PHY_REGS != NUM_PHY_REGS_DEF || NUM_ECRS != NUM_ECRS_DEF)
  begin : g_param_check
    $error("sic_dispatch_queue: packet field parameters differ from sic_packet_s layout");
  end

  sic_packet_t         mem [DEPTH];
  logic [PTR_W-1:0]    head, tail, head_next, tail_next, tail_base, scan_slot;
  logic [CNT_W-1:0]    count, count_next, count_base, keep;
  logic [IDX_W-1:0]    rr_ptr, rr_next, win_idx;
  logic [NUM_SICS-1:0] shadow, eligible, win_onehot;
  logic                win_any, empty, deq, enq, keep_found;

  // Wrap-aware age test: id is strictly younger than ref_id.
  function automatic logic is_younger(input logic [ID_WIDTH-1:0] id,
                                      input logic [ID_WIDTH-1:0] ref_id);
    logic [ID_WIDTH-1:0] diff;
    diff = id - ref_id;
    return !diff[ID_WIDTH-1] && (diff != '0);
  endfunction

  assign empty     = (count == '0);
  assign in_ready  = !rst && (count < CNT_W'(DEPTH));
  assign occupancy = count;
  assign eligible  = sic_req_instr & ~shadow;
  assign deq       = !empty && !flush_valid && win_any;
  assign enq       = in_pkt.valid && in_ready &&
                     !(flush_valid && is_younger(in_pkt.issue_id, flush_issue_id));

  sic_rr_picker #(.NUM_SICS(NUM_SICS)) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Survivor count on flush: offset of the oldest younger entry, or count if none.
  always_comb begin
    keep       = count;
    keep_found = 1'b0;
    scan_slot  = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_slot = head + PTR_W'(k);
      if (!keep_found && (CNT_W'(k) < count) &&
          is_younger(mem[scan_slot].issue_id, flush_issue_id)) begin
        keep       = CNT_W'(k);
        keep_found = 1'b1;
      end
    end
  end

  always_comb begin
    tail_base  = flush_valid ? head + keep[PTR_W-1:0] : tail;
    count_base = flush_valid ? keep : count;
    tail_next  = tail_base + PTR_W'(enq);
    count_next = count_base + CNT_W'(enq) - CNT_W'(deq);
    head_next  = head + PTR_W'(deq);
    rr_next    = (win_idx == IDX_W'(NUM_SICS - 1)) ? '0 : win_idx + 1'b1;
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_ptr <= '0;
      shadow <= '0;
      for (int i = 0; i < NUM_SICS; i++) sic_pkt_out[i] <= '0;
    end else begin
      head   <= head_next;
      tail   <= tail_next;
      count  <= count_next;
      shadow <= deq ? win_onehot : '0;
      if (deq) rr_ptr <= rr_next;
      for (int i = 0; i < NUM_SICS; i++) begin
        sic_pkt_out[i] <= '0;
        if (deq && win_onehot[i]) begin
          sic_pkt_out[i]       <= mem[head];
          sic_pkt_out[i].valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq) mem[tail_base] <= in_pkt;
  end

endmodule

// File: tb/tb_sic_dispatch_queue.sv
// Directed vector table plus randomized traffic against a queue-based reference model.
module tb_sic_dispatch_queue;
  import sic_dispatch_queue_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  sic_packet_s in_pkt;
  logic        in_ready;
  logic [N-1:0] sic_req_instr;
  sic_packet_s sic_pkt_out [N];
  logic        flush_valid;
  logic [7:0]  flush_issue_id;
  logic [2:0]  occupancy;

  sic_dispatch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .in_pkt         (in_pkt),
    .in_ready       (in_ready),
    .sic_req_instr  (sic_req_instr),
    .sic_pkt_out    (sic_pkt_out),
    .flush_valid    (flush_valid),
    .flush_issue_id (flush_issue_id),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  sic_packet_s q[$];
  int          m_rr;
  int          m_shadow;
  sic_packet_s m_out [N];

  typedef struct {
    logic       rst;
    logic       in_v;
    logic [7:0] in_id;
    logic [3:0] req;
    logic       fl;
    logic [7:0] fid;
    logic       exp_ready;
    logic [2:0] exp_occ;
    logic [3:0] exp_mask;
    logic [7:0] exp_id;
  } vec_t;

  vec_t tbl [29];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit younger(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = (int'(a) - int'(b) + 256) % 256;
    return (d >= 1) && (d <= 127);
  endfunction

  function automatic sic_packet_s mk_pkt(input logic v, input logic [7:0] id, input int salt);
    sic_packet_s p;
    p          = '0;
    p.valid    = v;
    p.issue_id = id;
    p.opcode   = 6'((int'(id) * 7 + salt) % 64);
    p.dst_reg  = 6'((int'(id) + 3 + salt) % 64);
    p.src_a    = 6'((int'(id) * 3 + salt) % 64);
    p.src_b    = 6'((int'(id) + 17) % 64);
    p.ecr_sel  = id[0];
    return p;
  endfunction

  // One clock: drive inputs, check in_ready, step model, clock, compare registered outputs.
  task automatic cycle(input logic r, input sic_packet_s p, input logic [3:0] req,
                       input logic fl, input logic [7:0] fid, output logic rdy_seen);
    bit ready;
    int w;
    int c;
    rst = r; in_pkt = p; sic_req_instr = req; flush_valid = fl; flush_issue_id = fid;
    #1;
    rdy_seen = in_ready;
    ready = !r && (q.size() < D);
    check("in_ready", 64'(in_ready), 64'(ready));
    for (int i = 0; i < N; i++) m_out[i] = '0;
    if (r) begin
      q.delete();
      m_rr = 0;
      m_shadow = 0;
    end else if (fl) begin
      for (int k = 0; k < q.size(); k++) begin
        if (younger(q[k].issue_id, fid)) begin
          while (q.size() > k) void'(q.pop_back());
          break;
        end
      end
      m_shadow = 0;
      if (p.valid && ready && !younger(p.issue_id, fid)) q.push_back(p);
    end else begin
      w = -1;
      if (q.size() > 0) begin
        for (int s = 0; s < N; s++) begin
          c = (m_rr + s) % N;
          if (req[c] && !m_shadow[c]) begin
            w = c;
            break;
          end
        end
      end
      if (w >= 0) begin
        m_out[w] = q.pop_front();
        m_out[w].valid = 1'b1;
        m_rr = (w + 1) % N;
        m_shadow = 1 << w;
      end else begin
        m_shadow = 0;
      end
      if (p.valid && ready) q.push_back(p);
    end
    @(posedge clk);
    #1;
    check("occupancy", 64'(occupancy), 64'(q.size()));
    for (int i = 0; i < N; i++)
      check($sformatf("sic_pkt_out%0d", i), 64'(sic_pkt_out[i]), 64'(m_out[i]));
  endtask

  function automatic vec_t v(input logic r, input logic iv, input logic [7:0] id,
                             input logic [3:0] req, input logic fl, input logic [7:0] fid,
                             input logic er, input logic [2:0] eo, input logic [3:0] em,
                             input logic [7:0] eid);
    vec_t t;
    t.rst = r; t.in_v = iv; t.in_id = id; t.req = req; t.fl = fl; t.fid = fid;
    t.exp_ready = er; t.exp_occ = eo; t.exp_mask = em; t.exp_id = eid;
    return t;
  endfunction

  initial begin
    logic       rdy;
    logic [3:0] mask;
    logic [7:0] next_id;
    sic_packet_s p;
    logic       r, fl;
    logic [7:0] fid;

    // Round-robin dispatch, SIC0 then SIC2, id3 waits.
    tbl[0]  = v(0, 1,   1, 4'b0000, 0,   0, 1, 1, 4'b0000,   0);
    tbl[1]  = v(0, 1,   2, 4'b0101, 0,   0, 1, 1, 4'b0001,   1);
    tbl[2]  = v(0, 1,   3, 4'b0101, 0,   0, 1, 1, 4'b0100,   2);
    tbl[3]  = v(0, 0,   0, 4'b0000, 0,   0, 1, 1, 4'b0000,   0);
    // Fill to full, extra enqueue ignored, one grant reopens in_ready.
    tbl[4]  = v(0, 1,   4, 4'b0000, 0,   0, 1, 2, 4'b0000,   0);
    tbl[5]  = v(0, 1,   5, 4'b0000, 0,   0, 1, 3, 4'b0000,   0);
    tbl[6]  = v(0, 1,   6, 4'b0000, 0,   0, 1, 4, 4'b0000,   0);
    tbl[7]  = v(0, 1,   7, 4'b0000, 0,   0, 0, 4, 4'b0000,   0);
    tbl[8]  = v(0, 1,   7, 4'b0010, 0,   0, 0, 3, 4'b0010,   3);
    // SIC1 held high: shadow blocks the next cycle.
    tbl[9]  = v(0, 0,   0, 4'b0010, 0,   0, 1, 3, 4'b0000,   0);
    tbl[10] = v(0, 0,   0, 4'b0010, 0,   0, 1, 2, 4'b0010,   4);
    tbl[11] = v(1, 0,   0, 4'b0000, 0,   0, 0, 0, 4'b0000,   0);
    // Flush at id 11: equal id survives, no dispatch during flush.
    tbl[12] = v(0, 1,  10, 4'b0000, 0,   0, 1, 1, 4'b0000,   0);
    tbl[13] = v(0, 1,  11, 4'b0000, 0,   0, 1, 2, 4'b0000,   0);
    tbl[14] = v(0, 1,  12, 4'b0000, 0,   0, 1, 3, 4'b0000,   0);
    tbl[15] = v(0, 1,  13, 4'b0000, 0,   0, 1, 4, 4'b0000,   0);
    tbl[16] = v(0, 0,   0, 4'b1111, 1,  11, 0, 2, 4'b0000,   0);
    tbl[17] = v(0, 0,   0, 4'b0001, 0,   0, 1, 1, 4'b0001,  10);
    tbl[18] = v(1, 0,   0, 4'b0000, 0,   0, 0, 0, 4'b0000,   0);
    // Id wrap across flush.
    tbl[19] = v(0, 1, 254, 4'b0000, 0,   0, 1, 1, 4'b0000,   0);
    tbl[20] = v(0, 1, 255, 4'b0000, 0,   0, 1, 2, 4'b0000,   0);
    tbl[21] = v(0, 1,   0, 4'b0000, 0,   0, 1, 3, 4'b0000,   0);
    tbl[22] = v(0, 1,   1, 4'b0000, 0,   0, 1, 4, 4'b0000,   0);
    tbl[23] = v(0, 0,   0, 4'b0000, 1, 255, 0, 2, 4'b0000,   0);
    tbl[24] = v(0, 0,   0, 4'b1000, 0,   0, 1, 1, 4'b1000, 254);
    // Same-cycle enqueue of a younger id is dropped; reset mid-dispatch.
    tbl[25] = v(0, 1,  20, 4'b0000, 1,  19, 1, 1, 4'b0000,   0);
    tbl[26] = v(0, 0,   0, 4'b0001, 0,   0, 1, 0, 4'b0001, 255);
    tbl[27] = v(0, 1,  30, 4'b0000, 0,   0, 1, 1, 4'b0000,   0);
    tbl[28] = v(1, 0,   0, 4'b0001, 0,   0, 0, 0, 4'b0000,   0);

    m_rr = 0;
    m_shadow = 0;
    for (int i = 0; i < N; i++) m_out[i] = '0;
    @(posedge clk);
    #1;
    cycle(1'b1, '0, '0, 1'b0, '0, rdy);
    cycle(1'b1, '0, '0, 1'b0, '0, rdy);

    for (int t = 0; t < 29; t++) begin
      cycle(tbl[t].rst, mk_pkt(tbl[t].in_v, tbl[t].in_id, 0), tbl[t].req,
            tbl[t].fl, tbl[t].fid, rdy);
      check($sformatf("vec%0d_ready", t), 64'(rdy), 64'(tbl[t].exp_ready));
      check($sformatf("vec%0d_occ", t), 64'(occupancy), 64'(tbl[t].exp_occ));
      for (int i = 0; i < N; i++) mask[i] = sic_pkt_out[i].valid;
      check($sformatf("vec%0d_mask", t), 64'(mask), 64'(tbl[t].exp_mask));
      for (int i = 0; i < N; i++) begin
        if (tbl[t].exp_mask[i])
          check($sformatf("vec%0d_id", t), 64'(sic_pkt_out[i].issue_id), 64'(tbl[t].exp_id));
      end
    end

    // Randomized traffic with in-order ids, occasional redirects and resets.
    next_id = 8'd100;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      fl = ($urandom_range(0, 11) == 0);
      fid = next_id - 8'($urandom_range(1, 6));
      p = mk_pkt($urandom_range(0, 3) != 0, next_id, int'($urandom_range(0, 63)));
      if (p.valid) next_id = next_id + 8'd1;
      cycle(r, p, 4'($urandom_range(0, 15)), fl, fid, rdy);
      if (fl && !r) next_id = fid + 8'd1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
